// File: rtl/dcache_ctrl.sv
// rtl/dcache_ctrl.sv - data-cache controller: broadcast lookup, TTL victim fill, bounded refill retry
module dcache_ctrl #(
  parameter int NUMLINES = 4,
  parameter int ADDRBITS = 32,
  parameter int DATABITS = 32,
  parameter int TTLBITS  = 8,
  parameter int MAXTTL   = 255,
  parameter int MAXRETRY = 3
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic [ADDRBITS-1:0]          cpu_addr,
  input  logic [DATABITS-1:0]          cpu_datain,
  input  logic                         cpu_rdreq,
  input  logic                         cpu_wrreq,
  output logic [DATABITS-1:0]          cpu_dataout,
  output logic                         cpu_valid,
  output logic                         cpu_err,
  output logic                         cpu_busy,
  output logic [ADDRBITS-1:0]          dcache_addr,
  output logic [DATABITS-1:0]          dcache_datain,
  output logic                         dcache_rdreq,
  output logic                         dcache_wrreq,
  input  logic [NUMLINES*DATABITS-1:0] line_out,
  input  logic [NUMLINES-1:0]          line_valid,
  input  logic [NUMLINES-1:0]          line_busy,
  output logic [NUMLINES-1:0]          line_fill,
  output logic                         multihit
);

  localparam int IDXBITS   = (NUMLINES > 1) ? $clog2(NUMLINES) : 1;
  localparam int RETRYBITS = (MAXRETRY > 0) ? $clog2(MAXRETRY + 1) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_LOOKUP,
    S_VICTIM,
    S_ARM,
    S_WAIT
  } state_t;

  state_t                state_q;
  logic [ADDRBITS-1:0]   addr_q;
  logic [DATABITS-1:0]   wdata_q;
  logic [DATABITS-1:0]   dout_q;
  logic                  is_wr_q;
  logic                  rdreq_q;
  logic                  wrreq_q;
  logic                  valid_q;
  logic                  err_q;
  logic                  busy_q;
  logic                  multi_q;
  logic [NUMLINES-1:0]   fill_q;
  logic [IDXBITS-1:0]    victim_q;
  logic [RETRYBITS-1:0]  retry_q;
  logic [TTLBITS-1:0]    ttl_q [NUMLINES];

  logic [IDXBITS-1:0]    hit_idx_d;
  logic                  multi_hit_d;
  logic [DATABITS-1:0]   hit_data_d;
  logic [TTLBITS-1:0]    ttl_hit_d [NUMLINES];
  logic                  vic_found_d;
  logic [IDXBITS-1:0]    vic_idx_d;
  logic [TTLBITS-1:0]    vic_ttl_d;

  assign cpu_dataout   = dout_q;
  assign cpu_valid     = valid_q;
  assign cpu_err       = err_q;
  assign cpu_busy      = busy_q;
  assign dcache_addr   = addr_q;
  assign dcache_datain = wdata_q;
  assign dcache_rdreq  = rdreq_q;
  assign dcache_wrreq  = wrreq_q;
  assign line_fill     = fill_q;
  assign multihit      = multi_q;

  // Lowest-index responding line wins; flag when more than one line answered
  always_comb begin
    hit_idx_d = '0;
    for (int i = NUMLINES - 1; i >= 0; i--) begin
      if (line_valid[i]) hit_idx_d = IDXBITS'(i);
    end
    multi_hit_d = (line_valid & (line_valid - NUMLINES'(1))) != '0;
    hit_data_d  = line_out[int'(hit_idx_d) * DATABITS +: DATABITS];
  end

  // Ages after a hit: winner refreshed to MAXTTL, every other line decays toward zero
  always_comb begin
    for (int i = 0; i < NUMLINES; i++) begin
      if (IDXBITS'(i) == hit_idx_d) begin
        ttl_hit_d[i] = TTLBITS'(MAXTTL);
      end else if (ttl_q[i] == '0) begin
        ttl_hit_d[i] = '0;
      end else begin
        ttl_hit_d[i] = ttl_q[i] - TTLBITS'(1);
      end
    end
  end

  // Victim: idle line with the smallest age, strict compare keeps ties on the lowest index
  always_comb begin
    vic_found_d = 1'b0;
    vic_idx_d   = '0;
    vic_ttl_d   = '1;
    for (int i = 0; i < NUMLINES; i++) begin
      if (!line_busy[i] && (!vic_found_d || ttl_q[i] < vic_ttl_d)) begin
        vic_found_d = 1'b1;
        vic_idx_d   = IDXBITS'(i);
        vic_ttl_d   = ttl_q[i];
      end
    end
  end

  // Request sequencer; every output is a register, strobes self-clear each cycle
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q  <= S_IDLE;
      addr_q   <= '0;
      wdata_q  <= '0;
      dout_q   <= '0;
      is_wr_q  <= 1'b0;
      rdreq_q  <= 1'b0;
      wrreq_q  <= 1'b0;
      valid_q  <= 1'b0;
      err_q    <= 1'b0;
      busy_q   <= 1'b0;
      multi_q  <= 1'b0;
      fill_q   <= '0;
      victim_q <= '0;
      retry_q  <= '0;
      for (int i = 0; i < NUMLINES; i++) ttl_q[i] <= '0;
    end else begin
      rdreq_q <= 1'b0;
      wrreq_q <= 1'b0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
      fill_q  <= '0;
      case (state_q)
        S_IDLE: begin
          // The CPU still holds its request during the completion cycle, so skip it then
          if ((cpu_rdreq || cpu_wrreq) && !valid_q) begin
            addr_q  <= cpu_addr;
            wdata_q <= cpu_datain;
            is_wr_q <= cpu_wrreq;
            rdreq_q <= !cpu_wrreq;
            wrreq_q <= cpu_wrreq;
            retry_q <= '0;
            busy_q  <= 1'b1;
            state_q <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          state_q <= S_LOOKUP;
        end
        S_LOOKUP: begin
          if (line_valid != '0) begin
            if (multi_hit_d) multi_q <= 1'b1;
            if (!is_wr_q) dout_q <= hit_data_d;
            ttl_q   <= ttl_hit_d;
            valid_q <= 1'b1;
            busy_q  <= 1'b0;
            state_q <= S_IDLE;
          end else if (retry_q == RETRYBITS'(MAXRETRY)) begin
            valid_q <= 1'b1;
            err_q   <= 1'b1;
            busy_q  <= 1'b0;
            state_q <= S_IDLE;
          end else begin
            state_q <= S_VICTIM;
          end
        end
        S_VICTIM: begin
          if (vic_found_d) begin
            fill_q           <= NUMLINES'(1) << vic_idx_d;
            victim_q         <= vic_idx_d;
            ttl_q[vic_idx_d] <= TTLBITS'(MAXTTL);
            retry_q          <= retry_q + RETRYBITS'(1);
            state_q          <= S_ARM;
          end
        end
        S_ARM: begin
          state_q <= S_WAIT;
        end
        S_WAIT: begin
          if (!line_busy[victim_q]) begin
            rdreq_q <= !is_wr_q;
            wrreq_q <= is_wr_q;
            state_q <= S_ISSUE;
          end
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dcache_ctrl.sv
// tb/tb_dcache_ctrl.sv - self-checking bench for dcache_ctrl with line-array emulation and TTL reference model
module tb_dcache_ctrl;
  localparam int N  = 4;
  localparam int DB = 32;

  logic              clk = 1'b0;
  logic              reset_n;
  logic [31:0]       cpu_addr, cpu_datain, cpu_dataout, dcache_addr, dcache_datain;
  logic              cpu_rdreq, cpu_wrreq, cpu_valid, cpu_err, cpu_busy;
  logic              dcache_rdreq, dcache_wrreq, multihit;
  logic [N*DB-1:0]   line_out;
  logic [N-1:0]      line_valid, line_busy, line_fill;

  dcache_ctrl dut (
    .clk(clk), .reset_n(reset_n),
    .cpu_addr(cpu_addr), .cpu_datain(cpu_datain), .cpu_rdreq(cpu_rdreq), .cpu_wrreq(cpu_wrreq),
    .cpu_dataout(cpu_dataout), .cpu_valid(cpu_valid), .cpu_err(cpu_err), .cpu_busy(cpu_busy),
    .dcache_addr(dcache_addr), .dcache_datain(dcache_datain),
    .dcache_rdreq(dcache_rdreq), .dcache_wrreq(dcache_wrreq),
    .line_out(line_out), .line_valid(line_valid), .line_busy(line_busy), .line_fill(line_fill),
    .multihit(multihit)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // line-array environment
  logic        tag_v [N];
  logic [31:0] tag_a [N];
  logic [31:0] ldata [N];
  int          busy_cnt [N];
  logic [3:0]  stuck;
  logic        fail_fill;
  logic [31:0] fill_word;

  // reference model
  int          m_ttl [N];
  logic        m_multi;
  logic [31:0] m_dout;
  logic [15:0] e_fw;
  int          e_nf;
  int          e_lat;
  logic        e_err;

  // observations
  logic [15:0] o_fw;
  int          o_nf, o_lat, o_nrd, o_nwr;
  logic        o_err, o_done, o_abort, o_busy_ok, o_after_valid, o_after_busy;
  logic [31:0] o_data, o_wdata;

  task automatic env_model_clear();
    for (int i = 0; i < N; i++) begin
      tag_v[i] = 1'b0; tag_a[i] = '0; ldata[i] = '0; busy_cnt[i] = 0; m_ttl[i] = 0;
    end
    stuck = '0; fail_fill = 1'b0; fill_word = '0; m_multi = 1'b0; m_dout = '0;
  endtask

  task automatic apply_reset();
    reset_n = 1'b0;
    cpu_addr = '0; cpu_datain = '0; cpu_rdreq = 1'b0; cpu_wrreq = 1'b0;
    line_out = '0; line_valid = '0; line_busy = '0;
    env_model_clear();
    repeat (2) @(posedge clk);
    #1;
  endtask

  // Transaction-level prediction from the cache rules: hit / victim by min age / retry limit
  task automatic predict(input logic [31:0] a, input logic wr, input int dur);
    logic        lv [N];
    logic [31:0] lt [N];
    logic [31:0] ld [N];
    logic [3:0]  hits;
    int          retry, v, w;
    for (int i = 0; i < N; i++) begin lv[i] = tag_v[i]; lt[i] = tag_a[i]; ld[i] = ldata[i]; end
    e_fw = '0; e_nf = 0; e_err = 1'b0; retry = 0;
    forever begin
      hits = '0;
      for (int i = 0; i < N; i++) if (lv[i] && lt[i] == a) hits[i] = 1'b1;
      if (hits != '0) begin
        w = 0;
        for (int i = N - 1; i >= 0; i--) if (hits[i]) w = i;
        if ($countones(hits) > 1) m_multi = 1'b1;
        if (!wr) m_dout = ld[w];
        for (int i = 0; i < N; i++) m_ttl[i] = (i == w) ? 255 : ((m_ttl[i] > 0) ? m_ttl[i] - 1 : 0);
        break;
      end
      if (retry == 3) begin e_err = 1'b1; break; end
      v = -1;
      for (int i = 0; i < N; i++) if (!stuck[i] && (v < 0 || m_ttl[i] < m_ttl[v])) v = i;
      if (v < 0) break;
      e_fw = {e_fw[11:0], 4'(1 << v)}; e_nf++;
      m_ttl[v] = 255; retry++;
      if (fail_fill) lv[v] = 1'b0;
      else begin lv[v] = 1'b1; lt[v] = a; ld[v] = fill_word; end
    end
    e_lat = 3 + e_nf * (5 + dur);
  endtask

  // Drive one CPU request while playing the role of the line array
  task automatic run_req(input logic [31:0] a, input logic [31:0] wd, input logic rd, input logic wr,
                         input int dur, input int abort_fill);
    logic        prev_strobe, prev_wr;
    logic [31:0] prev_addr, prev_wdata;
    logic [3:0]  prev_fill, lvd, bd;
    logic [N*DB-1:0] lo;
    o_fw = '0; o_nf = 0; o_lat = -1; o_nrd = 0; o_nwr = 0; o_err = 1'b0; o_done = 1'b0;
    o_abort = 1'b0; o_busy_ok = 1'b1; o_data = '0; o_wdata = '0;
    prev_strobe = 1'b0; prev_wr = 1'b0; prev_addr = '0; prev_wdata = '0; prev_fill = '0;
    cpu_addr = a; cpu_datain = wd; cpu_rdreq = rd; cpu_wrreq = wr;
    for (int cyc = 1; cyc <= 100; cyc++) begin
      @(posedge clk);
      #1;
      lvd = '0; bd = '0;
      for (int i = 0; i < N; i++) begin
        if (prev_fill[i]) busy_cnt[i] = dur;
        if (prev_strobe && tag_v[i] && tag_a[i] == prev_addr) begin
          lvd[i] = 1'b1;
          if (prev_wr) ldata[i] = prev_wdata;
        end
        if (busy_cnt[i] > 0) begin
          bd[i] = 1'b1;
          busy_cnt[i]--;
          if (busy_cnt[i] == 0) begin
            if (fail_fill) tag_v[i] = 1'b0;
            else begin tag_v[i] = 1'b1; tag_a[i] = a; ldata[i] = fill_word; end
          end
        end
        if (stuck[i]) bd[i] = 1'b1;
        lo[i*DB +: DB] = ldata[i];
      end
      line_valid = lvd; line_busy = bd; line_out = lo;
      if (dcache_rdreq) o_nrd++;
      if (dcache_wrreq) begin o_nwr++; o_wdata = dcache_datain; end
      prev_strobe = dcache_rdreq | dcache_wrreq; prev_wr = dcache_wrreq;
      prev_addr = dcache_addr; prev_wdata = dcache_datain; prev_fill = line_fill;
      if (line_fill != '0) begin o_fw = {o_fw[11:0], line_fill}; o_nf++; end
      if (abort_fill > 0 && o_nf == abort_fill && (bd & o_fw[3:0]) != '0) begin
        o_abort = 1'b1;
      end else if (cpu_valid) begin
        o_done = 1'b1; o_lat = cyc; o_err = cpu_err; o_data = cpu_dataout;
        cpu_rdreq = 1'b0; cpu_wrreq = 1'b0;
      end else if (cpu_busy !== 1'b1) begin
        o_busy_ok = 1'b0;
      end
      if (o_done || o_abort) break;
    end
    if (!o_abort) begin
      cpu_rdreq = 1'b0; cpu_wrreq = 1'b0;
      @(posedge clk);
      #1;
      line_valid = '0; line_busy = stuck;
      o_after_valid = cpu_valid; o_after_busy = cpu_busy;
    end
  endtask

  task automatic test_reset();
    apply_reset();
    checks++; if ({cpu_valid, cpu_err, cpu_busy, dcache_rdreq, dcache_wrreq, multihit} !== 6'b0) begin errors++; $display("FAIL reset_ctrl got %b want 000000", {cpu_valid, cpu_err, cpu_busy, dcache_rdreq, dcache_wrreq, multihit}); end
    checks++; if (line_fill !== 4'b0) begin errors++; $display("FAIL reset_fill got %b want 0000", line_fill); end
    checks++; if ({cpu_dataout, dcache_addr, dcache_datain} !== 96'b0) begin errors++; $display("FAIL reset_bus got %h want 0", {cpu_dataout, dcache_addr, dcache_datain}); end
    reset_n = 1'b1;
  endtask

  task automatic test_miss_fill();
    fill_word = 32'hCAFE;
    predict(32'h100, 1'b0, 3);
    run_req(32'h100, 32'h0, 1'b1, 1'b0, 3, 0);
    checks++; if (o_nf !== 1 || o_fw !== 16'h0001) begin errors++; $display("FAIL miss_fill got n=%0d v=%h want n=1 v=0001", o_nf, o_fw); end
    checks++; if (o_nrd !== 2 || o_nwr !== 0) begin errors++; $display("FAIL miss_restrobe got rd=%0d wr=%0d want rd=2 wr=0", o_nrd, o_nwr); end
    checks++; if (o_lat !== 11 || o_lat !== e_lat) begin errors++; $display("FAIL miss_lat got %0d want %0d", o_lat, e_lat); end
    checks++; if (o_data !== 32'hCAFE || o_err !== 1'b0) begin errors++; $display("FAIL miss_data got %h err=%b want 0000cafe err=0", o_data, o_err); end
    checks++; if (o_after_valid !== 1'b0 || o_after_busy !== 1'b0 || o_busy_ok !== 1'b1) begin errors++; $display("FAIL miss_pulse got v=%b b=%b bok=%b want 0 0 1", o_after_valid, o_after_busy, o_busy_ok); end
  endtask

  task automatic test_hit();
    tag_v[2] = 1'b1; tag_a[2] = 32'h200; ldata[2] = 32'h1234;
    predict(32'h200, 1'b0, 2);
    run_req(32'h200, 32'h0, 1'b1, 1'b0, 2, 0);
    checks++; if (o_lat !== 3 || o_nf !== 0) begin errors++; $display("FAIL hit_lat got lat=%0d fills=%0d want 3 0", o_lat, o_nf); end
    checks++; if (o_data !== 32'h1234) begin errors++; $display("FAIL hit_data got %h want 00001234", o_data); end
  endtask

  task automatic test_victim();
    stuck = 4'b0010;
    for (int k = 0; k < 2; k++) begin
      fill_word = $urandom;
      predict(32'h3000 + 32'(k * 4), 1'b0, 2);
      run_req(32'h3000 + 32'(k * 4), 32'h0, 1'b1, 1'b0, 2, 0);
      checks++; if (o_nf !== e_nf || o_fw !== e_fw) begin errors++; $display("FAIL victim%0d got n=%0d v=%h want n=%0d v=%h", k, o_nf, o_fw, e_nf, e_fw); end
      checks++; if (o_data !== m_dout || o_lat !== e_lat) begin errors++; $display("FAIL victim%0d_resp got d=%h lat=%0d want d=%h lat=%0d", k, o_data, o_lat, m_dout, e_lat); end
    end
    stuck = '0;
  endtask

  task automatic test_store();
    logic [31:0] wd;
    wd = $urandom;
    for (int i = 0; i < N; i++) if (tag_a[i] == 32'h300) tag_v[i] = 1'b0;
    tag_v[3] = 1'b1; tag_a[3] = 32'h300;
    predict(32'h300, 1'b1, 2);
    run_req(32'h300, wd, 1'b1, 1'b1, 2, 0);
    checks++; if (o_nwr !== 1 || o_nrd !== 0) begin errors++; $display("FAIL store_strobe got wr=%0d rd=%0d want wr=1 rd=0", o_nwr, o_nrd); end
    checks++; if (o_wdata !== wd) begin errors++; $display("FAIL store_wdata got %h want %h", o_wdata, wd); end
    checks++; if (o_lat !== 3 || o_data !== m_dout || o_after_valid !== 1'b0) begin errors++; $display("FAIL store_resp got lat=%0d d=%h nv=%b want lat=3 d=%h nv=0", o_lat, o_data, o_after_valid, m_dout); end
  endtask

  task automatic test_random();
    logic [31:0] a, wd;
    logic        rd, wr;
    int          kind, dur;
    for (int t = 0; t < 40; t++) begin
      a = 32'h4000 + 32'($urandom_range(0, 5) * 4);
      wd = $urandom;
      kind = $urandom_range(0, 2);
      rd = (kind != 1); wr = (kind != 0);
      dur = $urandom_range(1, 4);
      stuck = ($urandom_range(0, 3) == 0) ? 4'(1 << $urandom_range(0, 3)) : 4'b0;
      fail_fill = ($urandom_range(0, 9) == 0);
      fill_word = $urandom;
      predict(a, wr, dur);
      run_req(a, wd, rd, wr, dur, 0);
      checks++; if (o_nf !== e_nf || o_fw !== e_fw) begin errors++; $display("FAIL rnd%0d_fills got n=%0d v=%h want n=%0d v=%h", t, o_nf, o_fw, e_nf, e_fw); end
      checks++; if (o_lat !== e_lat || o_err !== e_err) begin errors++; $display("FAIL rnd%0d_lat got lat=%0d err=%b want lat=%0d err=%b", t, o_lat, o_err, e_lat, e_err); end
      checks++; if (o_data !== m_dout || multihit !== m_multi) begin errors++; $display("FAIL rnd%0d_data got d=%h mh=%b want d=%h mh=%b", t, o_data, multihit, m_dout, m_multi); end
      checks++; if (o_after_valid !== 1'b0 || o_busy_ok !== 1'b1) begin errors++; $display("FAIL rnd%0d_pulse got nv=%b bok=%b want 0 1", t, o_after_valid, o_busy_ok); end
    end
    stuck = '0; fail_fill = 1'b0;
  endtask

  task automatic test_multihit();
    logic [31:0] d1, d2;
    d1 = $urandom; d2 = ~d1;
    tag_v[1] = 1'b1; tag_a[1] = 32'h500; ldata[1] = d1;
    tag_v[2] = 1'b1; tag_a[2] = 32'h500; ldata[2] = d2;
    tag_v[0] = 1'b1; tag_a[0] = 32'h504; ldata[0] = 32'h5555;
    checks++; if (multihit !== 1'b0) begin errors++; $display("FAIL multihit_pre got %b want 0", multihit); end
    predict(32'h500, 1'b0, 2);
    run_req(32'h500, 32'h0, 1'b1, 1'b0, 2, 0);
    checks++; if (o_data !== d1 || multihit !== 1'b1) begin errors++; $display("FAIL multihit got d=%h mh=%b want d=%h mh=1", o_data, multihit, d1); end
    predict(32'h504, 1'b0, 2);
    run_req(32'h504, 32'h0, 1'b1, 1'b0, 2, 0);
    checks++; if (o_data !== 32'h5555 || multihit !== 1'b1) begin errors++; $display("FAIL multihit_sticky got d=%h mh=%b want d=00005555 mh=1", o_data, multihit); end
  endtask

  task automatic test_err_and_reset();
    fail_fill = 1'b1;
    predict(32'h600, 1'b0, 2);
    run_req(32'h600, 32'h0, 1'b1, 1'b0, 2, 0);
    checks++; if (o_nf !== 3 || o_fw !== e_fw) begin errors++; $display("FAIL err_fills got n=%0d v=%h want n=3 v=%h", o_nf, o_fw, e_fw); end
    checks++; if (o_err !== 1'b1 || o_lat !== 24 || o_data !== m_dout) begin errors++; $display("FAIL err_resp got err=%b lat=%0d d=%h want err=1 lat=24 d=%h", o_err, o_lat, o_data, m_dout); end
    checks++; if (o_after_valid !== 1'b0 || cpu_err !== 1'b0) begin errors++; $display("FAIL err_pulse got v=%b e=%b want 0 0", o_after_valid, cpu_err); end
    fail_fill = 1'b0;
    run_req(32'h700, 32'h0, 1'b1, 1'b0, 6, 1);
    checks++; if (o_abort !== 1'b1) begin errors++; $display("FAIL wait_reach got %b want 1", o_abort); end
    reset_n = 1'b0; cpu_rdreq = 1'b0;
    @(posedge clk);
    #1;
    checks++; if ({cpu_valid, cpu_err, cpu_busy, dcache_rdreq, dcache_wrreq, multihit, line_fill} !== 10'b0) begin errors++; $display("FAIL wait_reset got %b want 0", {cpu_valid, cpu_err, cpu_busy, dcache_rdreq, dcache_wrreq, multihit, line_fill}); end
    checks++; if ({cpu_dataout, dcache_addr, dcache_datain} !== 96'b0) begin errors++; $display("FAIL wait_reset_bus got %h want 0", {cpu_dataout, dcache_addr, dcache_datain}); end
    line_valid = '0; line_busy = '0;
    env_model_clear();
    reset_n = 1'b1;
    fill_word = $urandom;
    predict(32'h800, 1'b0, 2);
    run_req(32'h800, 32'h0, 1'b1, 1'b0, 2, 0);
    checks++; if (o_fw !== 16'h0001 || o_data !== fill_word) begin errors++; $display("FAIL post_reset got v=%h d=%h want v=0001 d=%h", o_fw, o_data, fill_word); end
  endtask

  initial begin
    test_reset();
    test_miss_fill();
    test_hit();
    test_victim();
    test_store();
    test_random();
    test_multihit();
    test_err_and_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
